// File: rtl/csr_pkg.sv
// Shared Zicsr definitions: funct3 encodings, well-known CSR addresses and the
// state encoding of the CSR access sequencer.
package csr_pkg;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] CYCLE   = 12'hC00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } csr_state_t;

    // The top quarter of the CSR address space is read-only.
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write datapath for CSRRW/CSRRS/CSRRC and their
// immediate forms; the caller resolves the source operand.
module csr_rmw_alu
    import csr_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] old_val,
    input  logic [31:0] src,
    output logic [31:0] new_val
);

    always_comb begin
        new_val = old_val;
        case (op)
            OP_RW:   new_val = src;
            OP_RS:   new_val = old_val | src;
            OP_RC:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction into read / write strobes on the csr port,
// returns the old CSR value for rd and flags illegal accesses.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int READ_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [11:0] addr_in,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rd_idx,
    input  logic [31:0] rs1_data,
    output logic        csr_read,
    output logic        csr_write,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_write_data,
    input  logic [31:0] csr_read_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        illegal
);

    localparam logic [1:0] LAST_RD = 2'(READ_LATENCY);

    csr_state_t  state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [1:0]  op_reg, op_next;
    logic [11:0] addr_reg, addr_next;
    logic [31:0] src_reg, src_next;
    logic        do_write_reg, do_write_next;
    logic [31:0] old_reg, old_next;

    logic        csr_read_reg, csr_read_next;
    logic        csr_write_reg, csr_write_next;
    logic [11:0] csr_addr_reg, csr_addr_next;
    logic [31:0] csr_write_data_reg, csr_write_data_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [31:0] rd_data_reg, rd_data_next;
    logic        illegal_reg, illegal_next;

    // Decode of the instruction presented on the inputs, used only at accept.
    logic [1:0]  in_op;
    logic [31:0] in_src;
    logic        in_do_read;
    logic        in_do_write;
    logic        in_illegal;

    assign in_op       = funct3[1:0];
    assign in_src      = funct3[2] ? {27'b0, rs1_idx} : rs1_data;
    assign in_do_read  = !((in_op == OP_RW) && (rd_idx == 5'd0));
    assign in_do_write = (in_op == OP_RW) || (rs1_idx != 5'd0);
    assign in_illegal  = (in_op == 2'b00) || (in_do_write && csr_is_read_only(addr_in));

    // One ALU serves both the write-only path (from IDLE, old value = 0) and
    // the read-modify-write path (from the last RD cycle, old = read data).
    logic [1:0]  alu_op;
    logic [31:0] alu_old;
    logic [31:0] alu_src;
    logic [31:0] alu_new;

    assign alu_op  = (state_reg == IDLE) ? in_op  : op_reg;
    assign alu_old = (state_reg == IDLE) ? 32'd0  : csr_read_data;
    assign alu_src = (state_reg == IDLE) ? in_src : src_reg;

    csr_rmw_alu u_alu (
        .op      (alu_op),
        .old_val (alu_old),
        .src     (alu_src),
        .new_val (alu_new)
    );

    always_comb begin
        state_next          = state_reg;
        cnt_next            = cnt_reg;
        op_next             = op_reg;
        addr_next           = addr_reg;
        src_next            = src_reg;
        do_write_next       = do_write_reg;
        old_next            = old_reg;
        csr_read_next       = 1'b0;
        csr_write_next      = 1'b0;
        csr_addr_next       = 12'd0;
        csr_write_data_next = 32'd0;
        done_next           = 1'b0;
        illegal_next        = 1'b0;
        rd_data_next        = rd_data_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next       = in_op;
                    addr_next     = addr_in;
                    src_next      = in_src;
                    do_write_next = in_do_write;
                    old_next      = 32'd0;
                    cnt_next      = 2'd0;
                    if (in_illegal) begin
                        state_next   = DONE;
                        done_next    = 1'b1;
                        illegal_next = 1'b1;
                        rd_data_next = 32'd0;
                    end else if (in_do_read) begin
                        state_next    = RD;
                        csr_read_next = 1'b1;
                        csr_addr_next = addr_in;
                    end else begin
                        state_next          = WR;
                        csr_write_next      = 1'b1;
                        csr_addr_next       = addr_in;
                        csr_write_data_next = alu_new;
                    end
                end
            end
            RD: begin
                if (cnt_reg == LAST_RD) begin
                    old_next = csr_read_data;
                    cnt_next = 2'd0;
                    if (do_write_reg) begin
                        state_next          = WR;
                        csr_write_next      = 1'b1;
                        csr_addr_next       = addr_reg;
                        csr_write_data_next = alu_new;
                    end else begin
                        state_next   = DONE;
                        done_next    = 1'b1;
                        rd_data_next = csr_read_data;
                    end
                end else begin
                    cnt_next      = cnt_reg + 2'd1;
                    csr_read_next = 1'b1;
                    csr_addr_next = addr_reg;
                end
            end
            WR: begin
                state_next   = DONE;
                done_next    = 1'b1;
                rd_data_next = old_reg;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_next = (state_next != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            cnt_reg            <= 2'd0;
            op_reg             <= 2'd0;
            addr_reg           <= 12'd0;
            src_reg            <= 32'd0;
            do_write_reg       <= 1'b0;
            old_reg            <= 32'd0;
            csr_read_reg       <= 1'b0;
            csr_write_reg      <= 1'b0;
            csr_addr_reg       <= 12'd0;
            csr_write_data_reg <= 32'd0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            rd_data_reg        <= 32'd0;
            illegal_reg        <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cnt_reg            <= cnt_next;
            op_reg             <= op_next;
            addr_reg           <= addr_next;
            src_reg            <= src_next;
            do_write_reg       <= do_write_next;
            old_reg            <= old_next;
            csr_read_reg       <= csr_read_next;
            csr_write_reg      <= csr_write_next;
            csr_addr_reg       <= csr_addr_next;
            csr_write_data_reg <= csr_write_data_next;
            busy_reg           <= busy_next;
            done_reg           <= done_next;
            rd_data_reg        <= rd_data_next;
            illegal_reg        <= illegal_next;
        end
    end

    assign csr_read       = csr_read_reg;
    assign csr_write      = csr_write_reg;
    assign csr_addr       = csr_addr_reg;
    assign csr_write_data = csr_write_data_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign rd_data        = rd_data_reg;
    assign illegal        = illegal_reg;

endmodule

// File: tb/tb_csr_access_unit.sv
// Drives two csr_access_unit instances (read latency 0 and 2) with the same
// instruction stream, each against its own behavioural CSR responder.
module tb_csr_access_unit;
    import csr_pkg::*;

    localparam int NDUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clr = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [11:0] addr_in = 12'd0;
    logic [4:0]  rs1_idx = 5'd0;
    logic [4:0]  rd_idx = 5'd0;
    logic [31:0] rs1_data = 32'd0;

    logic        csr_read [NDUT];
    logic        csr_write [NDUT];
    logic [11:0] csr_addr [NDUT];
    logic [31:0] csr_write_data [NDUT];
    logic [31:0] csr_read_data [NDUT];
    logic        busy [NDUT];
    logic        done [NDUT];
    logic [31:0] rd_data [NDUT];
    logic        illegal [NDUT];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_mem [8];

    always #5 clk = ~clk;

    function automatic int slot(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h341: return 1;
            12'hC00: return 2;
            12'h305: return 3;
            12'hC01: return 4;
            12'h800: return 5;
            12'h7FF: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [11:0] addr_of(input int i);
        case (i)
            0: return 12'h300;
            1: return 12'h341;
            2: return 12'hC00;
            3: return 12'h305;
            4: return 12'hC01;
            5: return 12'h800;
            default: return 12'h7FF;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 0 : 2;
            logic [31:0] mem [8];
            logic [31:0] d1, d2;

            always @(posedge clk) begin
                if (mem_clr) begin
                    for (int i = 0; i < 8; i++) mem[i] <= 32'd0;
                    d1 <= 32'd0;
                    d2 <= 32'd0;
                end else begin
                    if (csr_write[gi]) mem[slot(csr_addr[gi])] <= csr_write_data[gi];
                    d1 <= mem[slot(csr_addr[gi])];
                    d2 <= d1;
                end
            end

            if (L == 0) begin : g_comb
                assign csr_read_data[gi] = mem[slot(csr_addr[gi])];
            end else begin : g_delay
                assign csr_read_data[gi] = d2;
            end

            csr_access_unit #(.READ_LATENCY(L)) u_dut (
                .clk            (clk),
                .rst            (rst),
                .start          (start),
                .funct3         (funct3),
                .addr_in        (addr_in),
                .rs1_idx        (rs1_idx),
                .rd_idx         (rd_idx),
                .rs1_data       (rs1_data),
                .csr_read       (csr_read[gi]),
                .csr_write      (csr_write[gi]),
                .csr_addr       (csr_addr[gi]),
                .csr_write_data (csr_write_data[gi]),
                .csr_read_data  (csr_read_data[gi]),
                .busy           (busy[gi]),
                .done           (done[gi]),
                .rd_data        (rd_data[gi]),
                .illegal        (illegal[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    // Issue one instruction and watch both units for ten cycles after accept.
    task automatic run(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                       input logic [4:0] rdi, input logic [31:0] r1d, input bit poke);
        logic [1:0]  op;
        logic [31:0] src, old, nv, exp_rd;
        bit          wr, rdo, ill;
        int          lat, exp_rc, exp_wc;
        int          rcnt [NDUT];
        int          wcnt [NDUT];
        int          dcnt [NDUT];
        int          dcyc [NDUT];
        int          bad [NDUT];
        logic [31:0] wdat [NDUT];
        logic [31:0] rdv [NDUT];
        logic        illv [NDUT];

        op  = f3[1:0];
        src = f3[2] ? {27'd0, r1} : r1d;
        wr  = (op == 2'b01) || (r1 != 5'd0);
        rdo = !((op == 2'b01) && (rdi == 5'd0));
        ill = (op == 2'b00) || (wr && (a >= 12'hC00));
        old = ref_mem[slot(a)];
        case (op)
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = old;
        endcase
        exp_rd = (ill || !rdo) ? 32'd0 : old;

        for (int d = 0; d < NDUT; d++) begin
            rcnt[d] = 0; wcnt[d] = 0; dcnt[d] = 0; dcyc[d] = 0; bad[d] = 0;
            wdat[d] = 32'd0; rdv[d] = 32'hFFFF_FFFF; illv[d] = 1'bx;
        end

        funct3 = f3; addr_in = a; rs1_idx = r1; rd_idx = rdi; rs1_data = r1d; start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 10; n++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (csr_read[d]) rcnt[d]++;
                if (csr_write[d]) begin wcnt[d]++; wdat[d] = csr_write_data[d]; end
                if ((csr_read[d] || csr_write[d]) && csr_addr[d] !== a) bad[d]++;
                if (csr_read[d] && csr_write[d]) bad[d]++;
                if (done[d]) begin
                    dcnt[d]++;
                    if (dcyc[d] == 0) begin dcyc[d] = n; rdv[d] = rd_data[d]; illv[d] = illegal[d]; end
                end
            end
            if (poke && n == 1) begin
                start = 1'b1; funct3 = CSRRW; addr_in = a; rs1_idx = ~r1; rd_idx = 5'd1; rs1_data = ~r1d;
            end else begin
                start = 1'b0; funct3 = 3'($urandom); addr_in = 12'($urandom);
                rs1_idx = 5'($urandom); rd_idx = 5'($urandom); rs1_data = $urandom;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;

        for (int d = 0; d < NDUT; d++) begin
            lat    = (d == 0) ? 0 : 2;
            exp_rc = ill ? 0 : (rdo ? lat + 1 : 0);
            exp_wc = (ill || !wr) ? 0 : 1;
            chk("read_cycles", d, 32'(rcnt[d]), 32'(exp_rc));
            chk("write_cycles", d, 32'(wcnt[d]), 32'(exp_wc));
            chk("done_cycle", d, 32'(dcyc[d]), 32'(exp_rc + exp_wc + 1));
            chk("done_pulses", d, 32'(dcnt[d]), 32'd1);
            chk("rd_data", d, rdv[d], exp_rd);
            chk("illegal", d, 32'(illv[d]), 32'(ill));
            chk("strobe_addr", d, 32'(bad[d]), 32'd0);
            if (exp_wc == 1) chk("write_data", d, wdat[d], nv);
            chk("busy_after", d, 32'(busy[d]), 32'd0);
            chk("rd_data_held", d, rd_data[d], exp_rd);
        end
        if (!ill && wr) ref_mem[slot(a)] = nv;
        $display("txn f3=%b addr=%h rs1=%0d rd=%0d rs1_data=%h -> rd_data=%h illegal=%0d",
                 f3, a, r1, rdi, r1d, exp_rd, ill);
    endtask

    initial begin
        int wr_seen, done_seen;
        for (int i = 0; i < 8; i++) ref_mem[i] = 32'd0;

        rst = 1'b1; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_flags", d, {27'd0, csr_read[d], csr_write[d], busy[d], done[d], illegal[d]}, 32'd0);
            chk("reset_addr", d, {20'd0, csr_addr[d]}, 32'd0);
            chk("reset_wdata", d, csr_write_data[d], 32'd0);
            chk("reset_rd_data", d, rd_data[d], 32'd0);
        end
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;

        run(CSRRS,  MSTATUS, 5'd0,  5'd5, 32'h0,         1'b0);
        run(CSRRW,  MEPC,    5'd7,  5'd5, 32'h1234_5678, 1'b0);
        run(CSRRS,  MEPC,    5'd0,  5'd5, 32'h0,         1'b0);
        run(CSRRW,  MSTATUS, 5'd7,  5'd5, 32'hDEAD_BEEF, 1'b0);
        run(CSRRC,  MSTATUS, 5'd6,  5'd5, 32'h0000_FFFF, 1'b0);
        run(CSRRSI, MSTATUS, 5'h1F, 5'd5, 32'h0,         1'b0);
        run(CSRRW,  MEPC,    5'd9,  5'd0, 32'hAAAA_5555, 1'b0);
        run(3'b000, MEPC,    5'd9,  5'd5, 32'h1111_1111, 1'b0);
        run(CSRRW,  CYCLE,   5'd9,  5'd5, 32'h2222_2222, 1'b0);
        run(CSRRS,  CYCLE,   5'd0,  5'd1, 32'h0,         1'b0);
        run(CSRRCI, MSTATUS, 5'h0F, 5'd3, 32'h0,         1'b0);
        run(CSRRW,  MEPC,    5'd3,  5'd2, 32'hCAFE_F00D, 1'b1);

        // Abort a CSRRW to MEPC with reset while it is still reading.
        funct3 = CSRRW; addr_in = MEPC; rs1_idx = 5'd4; rd_idx = 5'd5; rs1_data = 32'hBADB_AD00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("abort_busy", d, 32'(busy[d]), 32'd0);
            chk("abort_strobes", d, {30'd0, csr_read[d], csr_write[d]}, 32'd0);
            chk("abort_done", d, 32'(done[d]), 32'd0);
        end
        rst = 1'b0;
        wr_seen = 0; done_seen = 0;
        for (int n = 0; n < 6; n++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (csr_write[d]) wr_seen++;
                if (done[d]) done_seen++;
            end
            @(posedge clk); #1;
        end
        chk("abort_no_write", 0, 32'(wr_seen), 32'd0);
        chk("abort_no_done", 0, 32'(done_seen), 32'd0);
        $display("txn abort CSRRW addr=%h by reset", MEPC);
        run(CSRRS, MEPC, 5'd0, 5'd5, 32'h0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [4:0] r1, rdi;
            r1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdi = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run(3'($urandom_range(0, 7)), addr_of($urandom_range(0, 6)), r1, rdi, $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
